// File: rtl/player_if.sv
// Controller <-> player bundle: instruction/strobe inputs and renderer/HUD status outputs.
interface player_if #(
  parameter int COORD_W = 8
);
  logic                   instr_valid;
  logic [15:0]            instruction;
  logic                   move_tick;
  logic [2*COORD_W-1:0]   position;
  logic [7:0]             size;
  logic [7:0]             hp;
  logic [7:0]             atk;
  logic                   is_dead;
  logic                   is_hurt;
  logic                   died;

  modport master (
    output instr_valid, instruction, move_tick,
    input  position, size, hp, atk, is_dead, is_hurt, died
  );

  modport slave (
    input  instr_valid, instruction, move_tick,
    output position, size, hp, atk, is_dead, is_hurt, died
  );
endinterface

// File: rtl/player_unit.sv
// Arena player entity: decodes game instructions, tracks HP/ATK/life state and
// steps position on move_tick with clamping to the arena bounds.
module player_unit #(
  parameter int COORD_W  = 8,
  parameter int ARENA_W  = 200,
  parameter int ARENA_H  = 200,
  parameter int SIZE     = 10,
  parameter int SPEED    = 4,
  parameter int HP_MAX   = 100,
  parameter int ATK_INIT = 10,
  parameter int X_INIT   = 14,
  parameter int Y_INIT   = 14,
  parameter int IFRAMES  = 8
) (
  input  logic     clk,
  input  logic     rst,
  player_if.slave  bus
);
  typedef enum logic [1:0] {ALIVE, HURT, DEAD} state_t;

  localparam logic [3:0] OP_HEAL    = 4'd1;
  localparam logic [3:0] OP_DAMAGE  = 4'd2;
  localparam logic [3:0] OP_ATK_ADD = 4'd3;
  localparam logic [3:0] OP_ATK_SET = 4'd4;
  localparam logic [3:0] OP_MOVE    = 4'd5;
  localparam logic [3:0] OP_HP_SET  = 4'd6;
  localparam logic [3:0] OP_REVIVE  = 4'd7;

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] MIN_C = CW1'(SIZE / 2);
  localparam logic [CW1-1:0] MAX_X = CW1'(ARENA_W - SIZE / 2);
  localparam logic [CW1-1:0] MAX_Y = CW1'(ARENA_H - SIZE / 2);
  localparam logic [CW1-1:0] STEP  = CW1'(SPEED);
  localparam logic [7:0]     HP_TOP = 8'(HP_MAX);
  localparam logic [7:0]     IFR    = 8'(IFRAMES);

  state_t               state, state_nxt;
  logic [COORD_W-1:0]   x, y, x_nxt, y_nxt;
  logic [7:0]           hp, hp_nxt, atk, atk_nxt, ifr_cnt, ifr_nxt;
  logic [1:0]           dir, dir_nxt;
  logic                 pend, pend_nxt;
  logic                 died_q, died_nxt;
  logic [3:0]           opc;
  logic [7:0]           op;
  logic                 unused_bits;

  assign opc         = bus.instr_valid ? bus.instruction[15:12] : 4'd0;
  assign op          = bus.instruction[11:4];
  assign unused_bits = ^bus.instruction[3:0];

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'd0 : a - b;
  endfunction

  // Compare before subtracting so the coordinate never underflows.
  function automatic logic [COORD_W-1:0] step_dec(input logic [COORD_W-1:0] c);
    logic [CW1-1:0] w;
    w = {1'b0, c};
    if (w < MIN_C + STEP) w = MIN_C;
    else                  w = w - STEP;
    return w[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] step_inc(input logic [COORD_W-1:0] c,
                                                  input logic [CW1-1:0] hi);
    logic [CW1-1:0] w;
    w = {1'b0, c} + STEP;
    if (w > hi) w = hi;
    return w[COORD_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    hp_nxt    = hp;
    atk_nxt   = atk;
    ifr_nxt   = ifr_cnt;
    dir_nxt   = dir;
    pend_nxt  = pend;
    if (state == DEAD) begin
      pend_nxt = 1'b0;
      if (opc == OP_REVIVE) begin
        hp_nxt    = HP_TOP;
        state_nxt = ALIVE;
        ifr_nxt   = 8'd0;
      end
    end else begin
      case (opc)
        OP_HEAL:    hp_nxt = sat_add(hp, op, HP_TOP);
        OP_DAMAGE:
          if (state == ALIVE && op != 8'd0) begin
            hp_nxt = sat_sub(hp, op);
            if (hp_nxt == 8'd0) begin
              state_nxt = DEAD;
            end else if (IFRAMES != 0) begin
              state_nxt = HURT;
              ifr_nxt   = IFR;
            end
          end
        OP_ATK_ADD: atk_nxt = sat_add(atk, op, 8'hFF);
        OP_ATK_SET: atk_nxt = op;
        OP_MOVE: begin
          dir_nxt  = op[1:0];
          pend_nxt = 1'b1;
        end
        OP_HP_SET: begin
          hp_nxt = (op > HP_TOP) ? HP_TOP : op;
          if (op == 8'd0) state_nxt = DEAD;
        end
        OP_REVIVE:  hp_nxt = HP_TOP;
        default: ;
      endcase
      if (state == HURT && state_nxt == HURT && bus.move_tick) begin
        if (ifr_cnt <= 8'd1) begin
          state_nxt = ALIVE;
          ifr_nxt   = 8'd0;
        end else begin
          ifr_nxt = ifr_cnt - 8'd1;
        end
      end
      if (state_nxt == DEAD) ifr_nxt = 8'd0;
      // A MOVE arriving with the tick is already visible through dir_nxt/pend_nxt.
      if (bus.move_tick && pend_nxt) begin
        pend_nxt = 1'b0;
        case (dir_nxt)
          2'd0:    x_nxt = step_dec(x);
          2'd1:    y_nxt = step_dec(y);
          2'd2:    x_nxt = step_inc(x, MAX_X);
          default: y_nxt = step_inc(y, MAX_Y);
        endcase
      end
    end
    died_nxt = (state_nxt == DEAD) && (state != DEAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ALIVE;
      x       <= COORD_W'(X_INIT);
      y       <= COORD_W'(Y_INIT);
      hp      <= HP_TOP;
      atk     <= 8'(ATK_INIT);
      ifr_cnt <= 8'd0;
      dir     <= 2'd0;
      pend    <= 1'b0;
      died_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      hp      <= hp_nxt;
      atk     <= atk_nxt;
      ifr_cnt <= ifr_nxt;
      dir     <= dir_nxt;
      pend    <= pend_nxt;
      died_q  <= died_nxt;
    end
  end

  assign bus.position = {x, y};
  assign bus.size     = 8'(SIZE);
  assign bus.hp       = hp;
  assign bus.atk      = atk;
  assign bus.is_dead  = (state == DEAD);
  assign bus.is_hurt  = (state == HURT);
  assign bus.died     = died_q;
endmodule
